// File: rtl/mdu_param.sv
// mdu_param: HI/LO multiply/divide unit with configurable multi-cycle latency, flush and busy handshake.
module mdu_param #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic             flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);
  localparam int W2 = 2 * WIDTH;
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [W2-1:0] ps, pu, acc, res, pend;
  logic [WIDTH-1:0] abs_a, abs_b, qu, ru, sq, sr, uq, ur;
  logic [CW-1:0] cnt;
  logic is_op, is_div, zb;

  assign is_op = MDUOp >= 4'd1 && MDUOp <= 4'd8;
  assign is_div = MDUOp == 4'd3 || MDUOp == 4'd4;
  assign zb = SrcB == '0;
  assign acc = {HI, LO};

  // signed division works on magnitudes; most-negative / -1 falls out naturally as LO=A, HI=0
  always_comb begin
    ps = {{WIDTH{SrcA[WIDTH-1]}}, SrcA} * {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
    pu = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};
    abs_a = SrcA[WIDTH-1] ? -SrcA : SrcA;
    abs_b = SrcB[WIDTH-1] ? -SrcB : SrcB;
    qu = abs_a / abs_b;
    ru = abs_a % abs_b;
    sq = (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) ? -qu : qu;
    sr = SrcA[WIDTH-1] ? -ru : ru;
    uq = SrcA / SrcB;
    ur = SrcA % SrcB;
    res = acc;
    case (MDUOp)
      4'd1: res = ps;
      4'd2: res = pu;
      4'd3: res = zb ? {SrcA, {WIDTH{1'b1}}} : {sr, sq};
      4'd4: res = zb ? {SrcA, {WIDTH{1'b1}}} : {ur, uq};
      4'd5: res = acc + ps;
      4'd6: res = acc + pu;
      4'd7: res = acc - ps;
      4'd8: res = acc - pu;
      default: res = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= '0;
      LO <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      pend <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
        cnt <= '0;
      end else if (busy) begin
        if (cnt == CW'(1)) begin
          {HI, LO} <= pend;
          busy <= 1'b0;
          done <= 1'b1;
          cnt <= '0;
        end else
          cnt <= cnt - CW'(1);
      end else if (start) begin
        if (is_op) begin
          pend <= res;
          busy <= 1'b1;
          cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (MDUOp == 4'd9)
          HI <= SrcA;
        else if (MDUOp == 4'd10)
          LO <= SrcA;
      end
    end
  end
endmodule

// File: tb/tb_mdu_param.sv
// tb_mdu_param: random and directed checks of mdu_param (32-bit default and 8-bit/1-cycle builds) against an arithmetic model.
module tb_mdu_param;
  logic clk = 0, reset_n = 0, start32 = 0, start8 = 0, flush = 0;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic [31:0] hi32, lo32;
  logic [7:0] hi8, lo8;
  logic busy32, done32, busy8, done8;
  int checks = 0, failures = 0;
  logic [63:0] st [2];

  always #5 clk = ~clk;

  mdu_param dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .MDUOp(op), .flush(flush),
    .SrcA(a), .SrcB(b), .HI(hi32), .LO(lo32), .busy(busy32), .done(done32)
  );

  mdu_param #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .MDUOp(op), .flush(flush),
    .SrcA(a[7:0]), .SrcB(b[7:0]), .HI(hi8), .LO(lo8), .busy(busy8), .done(done8)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(int s);
    return s != 0 ? {48'b0, hi8, lo8} : {hi32, lo32};
  endfunction
  function automatic logic ob_busy(int s);
    return s != 0 ? busy8 : busy32;
  endfunction
  function automatic logic ob_done(int s);
    return s != 0 ? done8 : done32;
  endfunction

  // {HI,LO} after one op, from plain 64-bit integer arithmetic
  function automatic logic [63:0] model(int w, logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [63:0] hl);
    logic [63:0] m1 = (64'd1 << w) - 64'd1;
    logic [63:0] m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
    longint sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    longint sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    logic [63:0] pu = {32'b0, x} * {32'b0, y};
    logic [63:0] ps = 64'(sx * sy);
    logic [63:0] q, r;
    case (o)
      4'd1: return ps & m2;
      4'd2: return pu & m2;
      4'd5: return (hl + ps) & m2;
      4'd6: return (hl + pu) & m2;
      4'd7: return (hl - ps) & m2;
      4'd8: return (hl - pu) & m2;
      4'd3, 4'd4: begin
        if (y == 0) return ({32'b0, x} << w) | m1;
        if (o == 4'd3) begin
          q = 64'(sx / sy);
          r = 64'(sx % sy);
        end else begin
          q = {32'b0, x / y};
          r = {32'b0, x % y};
        end
        return ((r & m1) << w) | (q & m1);
      end
      4'd9: return ({32'b0, x} << w) | (hl & m1);
      4'd10: return (hl & ~m1) | {32'b0, x};
      default: return hl;
    endcase
  endfunction

  function automatic logic [31:0] pick(int s);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return s != 0 ? 32'h80 : 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // called at a negedge; returns at the negedge after the op's effect is visible
  task automatic run_op(int s, logic [3:0] o, logic [31:0] xi, logic [31:0] yi);
    int w = s != 0 ? 8 : 32;
    int n = 0, want;
    logic [31:0] m = s != 0 ? 32'hff : 32'hffff_ffff;
    logic [31:0] x = xi & m, y = yi & m;
    logic [63:0] old = st[s];
    bit bad = 0;
    op = o; a = x; b = y;
    if (s != 0) start8 = 1; else start32 = 1;
    @(negedge clk);
    start8 = 0; start32 = 0;
    st[s] = model(w, o, x, y, old);
    if (o >= 4'd1 && o <= 4'd8) begin
      want = (o == 4'd3 || o == 4'd4) ? (s != 0 ? 3 : 10) : (s != 0 ? 1 : 5);
      while (ob_busy(s) && n < 50) begin
        n++;
        if (obs(s) !== old || ob_done(s)) bad = 1;
        if (n == 2) begin
          op = 4'd3; a = ~x; b = y ^ 32'h5;
          if (s != 0) start8 = 1; else start32 = 1;
        end
        @(negedge clk);
        start8 = 0; start32 = 0;
      end
      check($sformatf("op%0d_d%0d_cycles", o, s), 64'(n), 64'(want));
      check($sformatf("op%0d_d%0d_hold", o, s), 64'(bad), 64'd0);
      check($sformatf("op%0d_d%0d_done", o, s), 64'(ob_done(s)), 64'd1);
    end else begin
      check($sformatf("op%0d_d%0d_busy", o, s), {63'b0, ob_busy(s)}, 64'd0);
      check($sformatf("op%0d_d%0d_done", o, s), {63'b0, ob_done(s)}, 64'd0);
    end
    check($sformatf("op%0d_d%0d_hilo", o, s), obs(s), st[s]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit seen;
    st[0] = 0; st[1] = 0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi32, lo32}, 64'd0);
    check("reset_busy_done", {62'b0, busy32, done32}, 64'd0);
    reset_n = 1;
    @(negedge clk);

    run_op(0, 4'd1, 32'hffff_fffe, 32'd3);
    check("mult_const", {hi32, lo32}, 64'hffff_ffff_ffff_fffa);
    @(negedge clk);
    check("done_one_pulse", {63'b0, done32}, 64'd0);
    run_op(0, 4'd4, 32'd100, 32'd7);
    check("divu_const", {hi32, lo32}, {32'd2, 32'd14});
    run_op(0, 4'd3, 32'hffff_ff9c, 32'd7);
    check("div_const", {hi32, lo32}, 64'hffff_fffe_ffff_fff2);
    run_op(0, 4'd3, 32'h8000_0000, 32'hffff_ffff);
    check("div_ovf", {hi32, lo32}, 64'h0000_0000_8000_0000);
    run_op(0, 4'd4, 32'd5, 32'd0);
    check("divu_zero", {hi32, lo32}, 64'h0000_0005_ffff_ffff);
    run_op(0, 4'd9, 32'd1, 32'd0);
    run_op(0, 4'd10, 32'hffff_ffff, 32'd0);
    run_op(0, 4'd6, 32'd1, 32'd1);
    check("maddu_const", {hi32, lo32}, 64'h0000_0002_0000_0000);
    run_op(0, 4'd7, 32'd1, 32'd1);
    check("msub_const", {hi32, lo32}, 64'h0000_0001_ffff_ffff);

    // flush on busy cycle 3 of a MULT
    op = 4'd1; a = 32'd7; b = 32'd9; start32 = 1;
    @(negedge clk);
    start32 = 0;
    repeat (2) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy", {63'b0, busy32}, 64'd0);
    seen = 0;
    repeat (8) begin
      if (done32) seen = 1;
      @(negedge clk);
    end
    check("flush_no_done", {63'b0, seen}, 64'd0);
    check("flush_hilo", {hi32, lo32}, st[0]);

    // flush coinciding with start drops both MTHI and MULT
    op = 4'd9; a = 32'hdead_beef; start32 = 1; flush = 1;
    @(negedge clk);
    op = 4'd1;
    @(negedge clk);
    start32 = 0; flush = 0;
    check("startflush_busy", {63'b0, busy32}, 64'd0);
    check("startflush_hilo", {hi32, lo32}, st[0]);

    // flush on the commit edge of a DIV
    op = 4'd3; a = 32'd1000; b = 32'd3; start32 = 1;
    @(negedge clk);
    start32 = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("commitflush_busy_done", {62'b0, busy32, done32}, 64'd0);
    check("commitflush_hilo", {hi32, lo32}, st[0]);

    for (int i = 0; i < 60; i++)
      run_op(0, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10)), pick(0), pick(0));

    // asynchronous reset part-way through a DIV
    run_op(0, 4'd9, 32'h55, 32'd0);
    op = 4'd3; a = 32'd12345; b = 32'd7; start32 = 1;
    @(negedge clk);
    start32 = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("async_hilo", {hi32, lo32}, 64'd0);
    check("async_busy_done", {62'b0, busy32, done32}, 64'd0);
    st[0] = 0; st[1] = 0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    run_op(1, 4'd2, 32'hff, 32'hff);
    check("w8_multu_const", {48'b0, hi8, lo8}, 64'h0000_0000_0000_fe01);
    for (int i = 0; i < 30; i++)
      run_op(1, 4'($urandom_range(0, 10)), pick(1), pick(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit that sits beside the EX-stage ALU in the pipelined MIPS CPU.
- Owns the HI/LO registers and executes multi-cycle MULT/DIV/MADD/MSUB-class operations with configurable latency.
- Provides single-cycle MTHI/MTLO writes.
- Drives a busy flag the hazard unit uses to stall MFHI/MFLO and further MDU instructions, and accepts a flush for exception/interrupt cancellation.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥2).
- MULT_CYCLES, 5, busy cycles for multiply-class ops (≥1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  launch strobe, sampled on clk rising edge.
- MDUOp  in  4  operation code, valid with start.
- flush  in  1  cancels in-flight op (exception/eret).
- SrcA  in  WIDTH  operand A (rs).
- SrcB  in  WIDTH  operand B (rt).
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse on the cycle after HI/LO commit.

Behaviour:
- Reset (reset_n low, async): HI=0, LO=0, busy=0, done=0, internal counter=0, pending result cleared. Takes effect immediately, including mid-operation.
- MDUOp encoding:
  - 0 NOP
  - 1 MULT (signed)
  - 2 MULTU
  - 3 DIV (signed)
  - 4 DIVU
  - 5 MADD: {HI,LO} += signed A*B
  - 6 MADDU
  - 7 MSUB: {HI,LO} -= signed A*B
  - 8 MSUBU
  - 9 MTHI
  - 10 MTLO
  - 11–15 treated as NOP.
- Arithmetic:
  - Products are 2*WIDTH bits: {HI,LO} = product.
  - MADD/MSUB accumulate modulo 2^(2*WIDTH) against the {HI,LO} value at the start edge.
  - DIV/DIVU: LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend.
- Divide boundary cases:
  - Divide by zero (B=0), both DIV and DIVU: LO=all ones, HI=A.
  - Signed overflow (A=most-negative, B=-1): LO=A, HI=0.
- Launch: start=1, busy=0, flush=0, MDUOp in 1..8.
  - Operands are captured at that edge.
  - busy=1 from the next cycle for exactly N cycles, where N=MULT_CYCLES (ops 1,2,5,6,7,8) or DIV_CYCLES (3,4).
  - HI/LO update at the edge that ends the Nth busy cycle. busy falls at the same edge, and done=1 for the following cycle.
  - Before commit, HI/LO keep their old values.
- MTHI/MTLO: start=1, busy=0, flush=0.
  - HI (or LO) ← SrcA at that edge.
  - busy stays 0 and done stays 0.
- start while busy=1 is ignored entirely: no operand capture and no restart. The hazard unit guarantees this does not happen; the bench checks that it is harmless.
- flush=1:
  - Aborts any in-flight op. busy=0 next cycle, HI/LO unchanged, no done pulse.
  - flush and start in the same cycle: flush wins and the start is dropped, including MTHI/MTLO.
  - flush on the exact commit edge: flush wins and there is no commit.
- Back-to-back: a new start is accepted on the same cycle busy is observed 0, i.e. the cycle in which done=1.
- No overflow output: MDU ops never trap.

Test Plan:
- MULT, SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
- DIVU, SrcA=100, SrcB=7, then DIV with SrcA=0xFFFFFF9C (-100), SrcB=7 -> LO=14, HI=2 after 10 busy cycles; then LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- Divide boundaries -> DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; DIVU 5/0 gives LO=0xFFFFFFFF, HI=5.
- MTHI 0x1, MTLO 0xFFFFFFFF, then MADDU with A=1, B=1 -> HI=0x2, LO=0x0; then MSUB with A=1, B=1 -> HI=0x1, LO=0xFFFFFFFF.
- Flush cases -> MULT started then flush on busy cycle 3 leaves HI/LO at their prior values with busy=0 next cycle and no done; a start+flush coincident cycle leaves busy=0; start during busy does not alter the result.
- Async reset asserted mid-DIV (cycle 4) -> HI=LO=0 and busy=0 immediately without waiting for a clock; rerun with WIDTH=8, MULT_CYCLES=1: MULTU 0xFF*0xFF gives HI=0xFE, LO=0x01 after 1 busy cycle.
